// File: rtl/bg_seq_pkg.sv
// Shared types for the bandgap reference sequencer: FSM states and selection encodings.
package bg_seq_pkg;

  typedef enum logic [2:0] {
    StOff,
    StPowerup,
    StIdle,
    StBreak,
    StConnect,
    StActive
  } bg_state_e;

  localparam logic SEL_STD   = 1'b0;
  localparam logic SEL_DTMOS = 1'b1;

  // Buffer enable pattern for a given reference; always exactly one bit set.
  function automatic logic [1:0] sel_onehot(input logic sel);
    return (sel == SEL_DTMOS) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bg_seq_timer.sv
// Loadable down-counter shared by the settle, break, buffer and dwell intervals.
// A load of N makes o_done rise so that the owning state lasts exactly N cycles (0 acts as 1).
// The count saturates at zero and never wraps.
module bg_seq_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;
  logic             r_done;
  logic             w_done_d;

  // Next count: the load cycle itself counts as the first held cycle.
  always_comb begin
    w_cnt_d = '0;
    if (i_load) begin
      w_cnt_d = (i_load_val == '0) ? '0 : i_load_val - CNT_W'(1);
    end else begin
      w_cnt_d = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
    end
    w_done_d = (w_cnt_d == '0);
  end

  // Count and registered done flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_done <= w_done_d;
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/bg_ref_sequencer.sv
// Sequencer for the standard and DTMOS bandgap references: powers both cores, waits for them
// to settle, then connects one buffered reference at a time to the pad mux with
// break-before-make switching. Define BG_SEQ_AUTOSCAN_EN to add round-robin autoscan with a
// DWELL_CYC dwell per reference; without it ACTIVE holds until the host asks for a change.
module bg_ref_sequencer
  import bg_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned BREAK_CYC  = 4,
  parameter int unsigned BUF_CYC    = 64
`ifdef BG_SEQ_AUTOSCAN_EN
  ,
  parameter int unsigned DWELL_CYC  = 4096
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ena,
  input  logic       i_req_valid,
  input  logic       i_req_sel,
  output logic       o_req_ready,
  output logic [1:0] o_core_en,
  output logic [1:0] o_buf_en,
  output logic       o_amux_sel,
  output logic       o_amux_en,
  output logic       o_settled,
  output logic       o_cur_sel
);

  bg_state_e        r_state, w_state_d;
  logic             r_sel, w_sel_d;
  logic             r_req_ready, w_req_ready_d;
  logic [1:0]       r_core_en, w_core_en_d;
  logic [1:0]       r_buf_en, w_buf_en_d;
  logic             r_amux_en, w_amux_en_d;
  logic             r_settled, w_settled_d;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  assign w_accept = i_req_valid & r_req_ready;

  bg_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_done    (w_done)
  );

  // Next state, selection and timer loads; outputs are decoded from the state being entered
  // so they change on the same edge as the state.
  always_comb begin
    w_state_d  = r_state;
    w_sel_d    = r_sel;
    w_load     = 1'b0;
    w_load_val = '0;

    if (!i_ena) begin
      // Disable wins everywhere and drops any in-flight request.
      w_state_d = StOff;
      w_sel_d   = SEL_STD;
    end else begin
      case (r_state)
        StOff: begin
          w_state_d  = StPowerup;
          w_load     = 1'b1;
          w_load_val = CNT_W'(SETTLE_CYC);
        end
        StPowerup: begin
          if (w_done) w_state_d = StIdle;
        end
        StIdle: begin
          if (w_accept) begin
            w_sel_d    = i_req_sel;
            w_state_d  = StBreak;
            w_load     = 1'b1;
            w_load_val = CNT_W'(BREAK_CYC);
          end
        end
        StBreak: begin
          if (w_done) begin
            w_state_d  = StConnect;
            w_load     = 1'b1;
            w_load_val = CNT_W'(BUF_CYC);
          end
        end
        StConnect: begin
          if (w_done) begin
            w_state_d = StActive;
`ifdef BG_SEQ_AUTOSCAN_EN
            w_load     = 1'b1;
            w_load_val = CNT_W'(DWELL_CYC);
`endif
          end
        end
        StActive: begin
          // A host request beats a dwell expiry in the same cycle.
          if (w_accept && (i_req_sel != r_sel)) begin
            w_sel_d    = i_req_sel;
            w_state_d  = StBreak;
            w_load     = 1'b1;
            w_load_val = CNT_W'(BREAK_CYC);
          end
`ifdef BG_SEQ_AUTOSCAN_EN
          else if (w_accept) begin
            w_load     = 1'b1;
            w_load_val = CNT_W'(DWELL_CYC);
          end else if (w_done) begin
            w_sel_d    = ~r_sel;
            w_state_d  = StBreak;
            w_load     = 1'b1;
            w_load_val = CNT_W'(BREAK_CYC);
          end
`endif
        end
        default: begin
          w_state_d = StOff;
          w_sel_d   = SEL_STD;
        end
      endcase
    end

    w_core_en_d   = 2'b00;
    w_buf_en_d    = 2'b00;
    w_amux_en_d   = 1'b0;
    w_settled_d   = 1'b0;
    w_req_ready_d = 1'b0;
    case (w_state_d)
      StPowerup: begin
        w_core_en_d = 2'b11;
      end
      StIdle: begin
        w_core_en_d   = 2'b11;
        w_settled_d   = 1'b1;
        w_req_ready_d = 1'b1;
      end
      StBreak: begin
        w_core_en_d = 2'b11;
        w_settled_d = 1'b1;
      end
      StConnect: begin
        w_core_en_d = 2'b11;
        w_settled_d = 1'b1;
        w_buf_en_d  = sel_onehot(w_sel_d);
      end
      StActive: begin
        w_core_en_d   = 2'b11;
        w_settled_d   = 1'b1;
        w_buf_en_d    = sel_onehot(w_sel_d);
        w_amux_en_d   = 1'b1;
        w_req_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, selection and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StOff;
      r_sel       <= SEL_STD;
      r_req_ready <= 1'b0;
      r_core_en   <= 2'b00;
      r_buf_en    <= 2'b00;
      r_amux_en   <= 1'b0;
      r_settled   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sel       <= w_sel_d;
      r_req_ready <= w_req_ready_d;
      r_core_en   <= w_core_en_d;
      r_buf_en    <= w_buf_en_d;
      r_amux_en   <= w_amux_en_d;
      r_settled   <= w_settled_d;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_core_en   = r_core_en;
  assign o_buf_en    = r_buf_en;
  assign o_amux_sel  = r_sel;
  assign o_amux_en   = r_amux_en;
  assign o_settled   = r_settled;
  assign o_cur_sel   = r_sel;

endmodule

// File: tb/tb_bg_ref_sequencer.sv
// Bench for bg_ref_sequencer: timeline model (phase derived from elapsed cycles since the last
// enable / switch event) compared every cycle, plus directed literal checkpoints.
module tb_bg_ref_sequencer;

  localparam int SETTLE = 8;
  localparam int BRK    = 2;
  localparam int BUFC   = 4;
  localparam int DWELL  = 16;
`ifdef BG_SEQ_AUTOSCAN_EN
  localparam bit AUTOSCAN = 1'b1;
`else
  localparam bit AUTOSCAN = 1'b0;
`endif
  localparam int HOLD = AUTOSCAN ? 15 : 20;

  // Output vector: {ready, core_en[1:0], buf_en[1:0], amux_sel, amux_en, settled, cur_sel}
  localparam logic [8:0] V_OFF  = 9'b0_00_00_0_0_0_0;
  localparam logic [8:0] V_PWR  = 9'b0_11_00_0_0_0_0;
  localparam logic [8:0] V_IDLE = 9'b1_11_00_0_0_1_0;
  localparam logic [8:0] V_BRK1 = 9'b0_11_00_1_0_1_1;
  localparam logic [8:0] V_CON1 = 9'b0_11_10_1_0_1_1;
  localparam logic [8:0] V_ACT1 = 9'b1_11_10_1_1_1_1;
  localparam logic [8:0] V_BRK0 = 9'b0_11_00_0_0_1_0;
  localparam logic [8:0] V_CON0 = 9'b0_11_01_0_0_1_0;
  localparam logic [8:0] V_ACT0 = 9'b1_11_01_0_1_1_0;

  localparam int P_OFF = 0, P_PWR = 1, P_IDLE = 2, P_BRK = 3, P_CON = 4, P_ACT = 5;

  logic       clk, rst_n, ena, req_valid, req_sel;
  logic       req_ready, amux_sel, amux_en, settled, cur_sel;
  logic [1:0] core_en, buf_en;
  logic [8:0] outv;
  int         n_checks, n_fail;

  assign outv = {req_ready, core_en, buf_en, amux_sel, amux_en, settled, cur_sel};

  bg_ref_sequencer #(
    .CNT_W     (16),
    .SETTLE_CYC(SETTLE),
    .BREAK_CYC (BRK),
    .BUF_CYC   (BUFC)
`ifdef BG_SEQ_AUTOSCAN_EN
    ,
    .DWELL_CYC (DWELL)
`endif
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ena      (ena),
    .i_req_valid(req_valid),
    .i_req_sel  (req_sel),
    .o_req_ready(req_ready),
    .o_core_en  (core_en),
    .o_buf_en   (buf_en),
    .o_amux_sel (amux_sel),
    .o_amux_en  (amux_en),
    .o_settled  (settled),
    .o_cur_sel  (cur_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  bit         m_on, m_have, m_sel, m_acc;
  int         m_t0, m_tsw, m_tdw, cyc, m_ph;
  logic [8:0] m_exp;

  function automatic int phase_at(input int n);
    if (!m_on) return P_OFF;
    if (n - m_t0 < SETTLE) return P_PWR;
    if (!m_have) return P_IDLE;
    if (n - m_tsw < BRK) return P_BRK;
    if (n - m_tsw < BRK + BUFC) return P_CON;
    return P_ACT;
  endfunction

  function automatic logic [8:0] outputs_of(input int ph, input bit sel);
    logic [8:0] v;
    v = '0;
    if (ph == P_OFF) return v;
    v[8]   = (ph == P_IDLE) || (ph == P_ACT);
    v[7:6] = 2'b11;
    v[5:4] = ((ph == P_CON) || (ph == P_ACT)) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    v[3]   = sel;
    v[2]   = (ph == P_ACT);
    v[1]   = (ph != P_PWR);
    v[0]   = sel;
    return v;
  endfunction

  initial begin
    m_on = 0; m_have = 0; m_sel = 0; m_acc = 0;
    m_t0 = 0; m_tsw = 0; m_tdw = 0; cyc = 0; m_ph = P_OFF;
    m_exp = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_on = 0; m_have = 0; m_sel = 0; m_exp = '0;
      end else begin
        cyc++;
        m_ph  = phase_at(cyc - 1);
        m_acc = req_valid && ((m_ph == P_IDLE) || (m_ph == P_ACT));
        if (!ena) begin
          m_on = 0; m_have = 0; m_sel = 0;
        end else if (m_ph == P_OFF) begin
          m_on = 1; m_t0 = cyc;
        end else if ((m_ph == P_IDLE) && m_acc) begin
          m_have = 1; m_sel = req_sel; m_tsw = cyc; m_tdw = cyc + BRK + BUFC;
        end else if (m_ph == P_ACT) begin
          if (m_acc && (req_sel != m_sel)) begin
            m_sel = req_sel; m_tsw = cyc; m_tdw = cyc + BRK + BUFC;
          end else if (m_acc) begin
            m_tdw = cyc;
          end else if (AUTOSCAN && (cyc - m_tdw == DWELL)) begin
            m_sel = !m_sel; m_tsw = cyc; m_tdw = cyc + BRK + BUFC;
          end
        end
        m_exp = outputs_of(phase_at(cyc), m_sel);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_checks++;
        if (outv !== m_exp) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t got=%b want=%b", $time, outv, m_exp);
        end
        n_checks++;
        if (buf_en == 2'b11) begin
          n_fail++;
          $display("FAIL buf_two_hot t=%0t got=%b want=one-hot-or-zero", $time, buf_en);
        end
        n_checks++;
        if (amux_en && !buf_en[amux_sel]) begin
          n_fail++;
          $display("FAIL amux_without_buf t=%0t got buf_en=%b amux_sel=%b want buf_en[amux_sel]=1",
                   $time, buf_en, amux_sel);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] want);
    n_checks++;
    if (outv !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, outv, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic request(input logic sel);
    req_valid = 1'b1;
    req_sel   = sel;
    step(1);
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ena = 1'b0; req_valid = 1'b0; req_sel = 1'b0;
    step(2);
    chk("reset_outputs", V_OFF);
    rst_n = 1'b1;
    step(1);
    chk("off_ena_low", V_OFF);

    // Power-up and settle.
    ena = 1'b1;
    step(1); chk("pwr_first", V_PWR);
    step(7); chk("pwr_last", V_PWR);
    step(1); chk("idle_reached", V_IDLE);

    // First selection: DTMOS.
    request(1'b1);
    chk("sel1_brk_d0", V_BRK1);
    step(1); chk("sel1_brk_d1", V_BRK1);
    step(1); chk("sel1_con_d2", V_CON1);
    step(3); chk("sel1_con_d5", V_CON1);
    step(1); chk("sel1_act", V_ACT1);

    // Switch to standard.
    request(1'b0);
    chk("sel0_brk_d0", V_BRK0);
    step(1); chk("sel0_brk_d1", V_BRK0);
    step(1); chk("sel0_con_d2", V_CON0);
    step(3); chk("sel0_con_d5", V_CON0);
    step(1); chk("sel0_act", V_ACT0);

    // Same-selection request is a no-op.
    request(1'b0);
    chk("same_sel_d0", V_ACT0);
    for (int k = 1; k <= HOLD; k++) begin
      step(1); chk("same_sel_hold", V_ACT0);
    end

`ifdef BG_SEQ_AUTOSCAN_EN
    step(1);  chk("scan_toggle_brk1", V_BRK1);
    step(5);  chk("scan_con1", V_CON1);
    step(1);  chk("scan_act1", V_ACT1);
    step(16); chk("scan_back_brk0", V_BRK0);
    step(6);  chk("scan_act0", V_ACT0);
    step(15);
    request(1'b0);
    chk("expiry_req_keeps", V_ACT0);
    step(15); chk("dwell_restarted", V_ACT0);
    step(1);  chk("dwell_expiry2", V_BRK1);
`else
    request(1'b1);
    chk("to_sel1_brk", V_BRK1);
`endif

    // Disable during CONNECT with a request in flight.
    step(3); chk("con_before_drop", V_CON1);
    ena = 1'b0; req_valid = 1'b1; req_sel = 1'b0;
    step(1); chk("ena_drop_off", V_OFF);
    step(1); chk("off_hold", V_OFF);
    req_valid = 1'b0; ena = 1'b1;
    step(1); chk("reenable_pwr", V_PWR);
    step(7); chk("reenable_pwr_last", V_PWR);
    step(1); chk("reenable_idle", V_IDLE);

    // Asynchronous reset mid power-up.
    ena = 1'b0;
    step(1); chk("off_before_pulse", V_OFF);
    ena = 1'b1;
    step(4); chk("pwr_mid", V_PWR);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", V_OFF);
    step(1); chk("reset_hold", V_OFF);
    rst_n = 1'b1;
    step(1); chk("post_reset_pwr", V_PWR);
    step(7); chk("post_reset_pwr_last", V_PWR);
    step(1); chk("post_reset_idle", V_IDLE);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
